// File: rtl/bias_scalar_feeder_pkg.sv
// Shared types and defaults for the bias scalar feeder.
// Holds the FSM state encoding and the bias word type.
package bias_scalar_feeder_pkg;

    localparam int DEF_N_COLS = 2;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        COMMIT
    } feeder_state_t;

    typedef logic signed [15:0] bias_word_t;

endpackage

// File: rtl/bias_bank_reg.sv
// Shadow/active bias register pair.
// Shadow fills word by word; active updates only on a bulk commit.
module bias_bank_reg
    import bias_scalar_feeder_pkg::*;
#(
    parameter int N_COLS = DEF_N_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [IDX_W-1:0]         i_wr_idx,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_commit,
    output logic [N_COLS*DATA_W-1:0] o_active
);

    logic [DATA_W-1:0]        r_shadow [N_COLS];
    logic [N_COLS*DATA_W-1:0] r_active;

    // Shadow capture of returning UB words, one lane per write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_COLS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (i_wr_en && (int'(i_wr_idx) < N_COLS)) begin
            r_shadow[i_wr_idx] <= i_wr_data;
        end
    end

    // Atomic copy of the whole shadow bank into the active bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= '0;
        end else if (i_commit) begin
            for (int i = 0; i < N_COLS; i++) begin
                r_active[i*DATA_W +: DATA_W] <= r_shadow[i];
            end
        end
    end

    assign o_active = r_active;

endmodule

// File: rtl/bias_scalar_feeder.sv
// Fetches N_COLS bias words from the unified buffer and commits
// them to the active bank only while the array output is idle.
module bias_scalar_feeder
    import bias_scalar_feeder_pkg::*;
#(
    parameter int N_COLS = DEF_N_COLS,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [N_COLS-1:0]        col_valid_in,
    output logic                     ub_rd_en,
    output logic [ADDR_W-1:0]        ub_rd_addr,
    input  logic [DATA_W-1:0]        ub_rd_data,
    output logic [N_COLS*DATA_W-1:0] bias_scalar_out,
    output logic                     bias_loaded,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N_COLS - 1);

    feeder_state_t     r_state;
    logic [IDX_W-1:0]  r_k;
    logic [IDX_W-1:0]  r_cj;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_en;
    logic              r_rd_q;
    logic              r_busy;
    logic              r_done;
    logic              r_loaded;

    logic w_start;
    logic w_commit;

    assign w_start  = (r_state == IDLE) && start;
    assign w_commit = (r_state == COMMIT) && (col_valid_in == '0);

    // Load sequencer: issue reads, drain the last word, wait for a quiet array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_addr   <= '0;
            r_rd_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_loaded <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr  <= base_addr;
                        r_k     <= '0;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (r_k == LAST_K) begin
                        r_rd_en <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_k    <= r_k + IDX_W'(1);
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    r_state <= COMMIT;
                end
                COMMIT: begin
                    if (w_commit) begin
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_loaded <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Capture tracker: UB data lands one cycle after each read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_q <= 1'b0;
            r_cj   <= '0;
        end else begin
            r_rd_q <= r_rd_en;
            if (w_start) begin
                r_cj <= '0;
            end else if (r_rd_q) begin
                r_cj <= r_cj + IDX_W'(1);
            end
        end
    end

    bias_bank_reg #(
        .N_COLS (N_COLS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_rd_q),
        .i_wr_idx  (r_cj),
        .i_wr_data (ub_rd_data),
        .i_commit  (w_commit),
        .o_active  (bias_scalar_out)
    );

    assign ub_rd_en    = r_rd_en;
    assign ub_rd_addr  = r_addr;
    assign bias_loaded = r_loaded;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: doc/bias_scalar_feeder.md
# bias_scalar_feeder

Unified-buffer-side source of the per-column bias scalars consumed by the bias stage. On a `start` command it reads `N_COLS` consecutive Q8.8 bias words from the unified buffer into a shadow bank, then commits them atomically to the active bank, which drives each column's bias input. The commit happens only when no column is receiving valid systolic-array output, so a layer's bias set never changes mid-stream.

## Interface
Parameters:
- `N_COLS`, 2: number of systolic columns and bias lanes.
- `DATA_W`, 16: bias word width (signed Q8.8, raw bits).
- `ADDR_W`, 8: unified buffer address width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: one-cycle load request; sampled only in IDLE.
- `base_addr`  in  ADDR_W: UB address of lane 0 bias; sampled with `start`.
- `col_valid_in`  in  N_COLS: per-column systolic valid, the same signals that drive the bias stage's valid input.
- `ub_rd_en`  out  1: UB read strobe.
- `ub_rd_addr`  out  ADDR_W: UB read address.
- `ub_rd_data`  in  DATA_W: UB read data, valid exactly one cycle after `ub_rd_en`.
- `bias_scalar_out`  out  N_COLS*DATA_W: active bias bank; lane i at bits [i*DATA_W +: DATA_W].
- `bias_loaded`  out  1: high once any set has been committed since reset.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse in the cycle after a commit.

## Operation
- States: IDLE, FETCH, DRAIN, COMMIT.
- IDLE:
  - `start`=1 latches `base_addr`, clears read index `k`, and moves to FETCH.
  - `start` in any other state is ignored. It is not queued.
- FETCH:
  - Registered outputs: `ub_rd_en`=1, `ub_rd_addr`=base+k. The address wraps modulo 2^ADDR_W.
  - `k` increments each cycle. After read `k`=N_COLS-1 is issued, the FSM moves to DRAIN.
- Capture:
  - The data returned for read j is written to `shadow[j]` on the edge after that read's cycle.
  - A capture counter tracks j independently of `k`.
- DRAIN: one cycle, `ub_rd_en`=0. It captures the final word, then moves to COMMIT.
- COMMIT:
  - If `col_valid_in`==0 at the edge, `active <= shadow`, `done` is set for one cycle, and the FSM returns to IDLE.
  - Otherwise the FSM holds in COMMIT. There is no timeout.
- `bias_scalar_out` reflects only the active bank. It never shows partially loaded shadow data.
- No arithmetic is performed; words pass through bit-exact (sign preserved).
- Reset, asserted at any time including mid-fetch:
  - All outputs go to 0: `ub_rd_en`, `ub_rd_addr`, `bias_scalar_out`, `bias_loaded`, `busy`, `done`.
  - The shadow bank clears, and the FSM returns to IDLE.
  - UB data returning after reset is discarded.

## Timing
- Edge E0 samples `start`.
- `ub_rd_en` is high during cycles E0..E(N_COLS-1)+, with addresses base..base+N_COLS-1.
- Last capture is at E(N_COLS+1).
- With `col_valid_in` idle, the commit edge is E(N_COLS+2). The new `bias_scalar_out` and `done` are visible in the cycle after that edge.
- Minimum start-to-start interval is N_COLS+3 cycles.
- Each cycle the commit is blocked by `col_valid_in` adds one cycle.
- `busy` rises in the cycle after E0 and falls in the cycle `done` is high.
- Bias lanes are constant in every cycle in which any `col_valid_in` bit is high.

## Structure
- A shared package holds:
  - the state enum `feeder_state_t` (IDLE, FETCH, DRAIN, COMMIT);
  - the default parameter constants;
  - the `bias_word_t` typedef (signed [15:0]).
- Sub-module `bias_bank_reg`: N_COLS-entry shadow/active register pair with indexed write and a bulk commit. The FSM and address counter live in the top module.

## Test plan
- Load: mem[0x10]=0x0100 and mem[0x11]=0xFF80, `start` with base=0x10, valid idle.
  - Required: reads at 0x10 then 0x11; `done` at E4; lanes = {0xFF80, 0x0100}; `bias_loaded`=1.
- Blocked commit: same load with `col_valid_in`=2'b01 held from E2 to E7.
  - Required: lanes keep their old values through E7; commit at the first edge with valid=0; `done` one cycle later.
- Wrap: base=0xFF, mem[0xFF]=0x0001, mem[0x00]=0x0002.
  - Required: `ub_rd_addr` goes 0xFF then 0x00; lanes = {0x0002, 0x0001}.
- Ignored start: pulse `start` with base=0x40 during FETCH of a load from 0x10.
  - Required: only addresses 0x10 and 0x11 are read; exactly one `done`.
- Mid-fetch reset: assert `rst` in the cycle after E0.
  - Required: all outputs 0 immediately; FSM IDLE; a subsequent load completes normally with `done` exactly once.
- Back-to-back layers: load set A, then `start` again in the cycle `done` is seen.
  - Required: set B commits N_COLS+3 cycles later; lanes hold A in between.
